ct_l2c_csr_resp: RTL and testbench

// - L2C-side responder for the core CSR request channel: accepts core CSR requests (sel + 80-bit op/wdata payload),

---
 rtl/ct_l2c_csr_pkg.sv | 19 +
 rtl/ct_l2c_csr_regbank.sv | 40 ++++
 rtl/ct_l2c_csr_resp.sv | 110 +++++++++++
 tb/tb_ct_l2c_csr_resp.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ct_l2c_csr_pkg.sv
// Shared constants and FSM state type for the L2C-side CSR responder.
package ct_l2c_csr_pkg;

  localparam int OP_WR_BIT  = 15;
  localparam int OP_IDX_MSB = 7;
  localparam int OP_IDX_LSB = 0;
  localparam int PAYLOAD_W  = 80;
  localparam int RDATA_W    = 128;
  localparam int ERR_BIT    = 64;
  localparam int DATA_W     = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CMPLT,
    WAITDRP
  } csr_state_e;

endpackage

// File: rtl/ct_l2c_csr_regbank.sv
// Local 64-bit CSR bank: one write port, one read port, index 0 is a read-only version word.
module ct_l2c_csr_regbank
  import ct_l2c_csr_pkg::*;
#(
  parameter int unsigned       NUM_REGS = 8,
  parameter logic [DATA_W-1:0] VERSION  = 64'h0000_0000_0001_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [7:0]        idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  assign err = 32'(idx) >= NUM_REGS;

  // Index 0 and out-of-range indices never match the loop, so they are never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (we) begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        if (idx == 8'(i)) regs[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (idx == 8'd0) rdata = VERSION;
    for (int i = 1; i < int'(NUM_REGS); i++) begin
      if (idx == 8'(i)) rdata = regs[i];
    end
  end

endmodule

// File: rtl/ct_l2c_csr_resp.sv
// L2C CSR responder: edge-detects the core request level, accesses the CSR bank after
// RESP_LAT wait cycles and returns a one-cycle completion pulse with registered read data.
module ct_l2c_csr_resp
  import ct_l2c_csr_pkg::*;
#(
  parameter int unsigned       NUM_REGS = 8,
  parameter int unsigned       RESP_LAT = 2,
  parameter logic [DATA_W-1:0] VERSION  = 64'h0000_0000_0001_0000
) (
  input  logic                 coreclk,
  input  logic                 cpurst,
  input  logic                 biu_pad_csr_sel,
  input  logic [PAYLOAD_W-1:0] biu_pad_csr_wdata,
  output logic                 pad_biu_csr_cmplt,
  output logic [RDATA_W-1:0]   pad_biu_csr_rdata,
  output logic                 l2c_csr_busy
);

  csr_state_e        state;
  logic              sel_ff;
  logic [3:0]        cnt;
  logic              op_wr;
  logic [7:0]        op_idx;
  logic [DATA_W-1:0] wdata_q;
  logic [15:0]       req_op;
  logic              start;
  logic              access;
  logic [DATA_W-1:0] bank_rdata;
  logic              bank_err;
  logic [RDATA_W-1:0] rdata_nxt;
  logic              unused_op_bits;

  assign req_op         = biu_pad_csr_wdata[PAYLOAD_W-1:DATA_W];
  assign unused_op_bits = ^req_op[14:8];

  assign start  = biu_pad_csr_sel & ~sel_ff & (state == IDLE);
  assign access = (state == ACCESS) && (cnt == 4'd0);

  ct_l2c_csr_regbank #(
    .NUM_REGS (NUM_REGS),
    .VERSION  (VERSION)
  ) u_regbank (
    .clk   (coreclk),
    .rst   (cpurst),
    .we    (access & op_wr),
    .idx   (op_idx),
    .wdata (wdata_q),
    .rdata (bank_rdata),
    .err   (bank_err)
  );

  // Writes to index 0 are dropped, so they return the version word rather than an echo.
  always_comb begin
    rdata_nxt = '0;
    if (bank_err) begin
      rdata_nxt[ERR_BIT] = 1'b1;
    end else if (op_wr && (op_idx != 8'd0)) begin
      rdata_nxt[DATA_W-1:0] = wdata_q;
    end else begin
      rdata_nxt[DATA_W-1:0] = bank_rdata;
    end
  end

  always_ff @(posedge coreclk or posedge cpurst) begin
    if (cpurst) begin
      state             <= IDLE;
      sel_ff            <= 1'b0;
      cnt               <= 4'd0;
      op_wr             <= 1'b0;
      op_idx            <= 8'd0;
      wdata_q           <= '0;
      pad_biu_csr_cmplt <= 1'b0;
      pad_biu_csr_rdata <= '0;
      l2c_csr_busy      <= 1'b0;
    end else begin
      sel_ff            <= biu_pad_csr_sel;
      pad_biu_csr_cmplt <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_wr        <= req_op[OP_WR_BIT];
            op_idx       <= req_op[OP_IDX_MSB:OP_IDX_LSB];
            wdata_q      <= biu_pad_csr_wdata[DATA_W-1:0];
            cnt          <= 4'(RESP_LAT);
            l2c_csr_busy <= 1'b1;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            pad_biu_csr_cmplt <= 1'b1;
            pad_biu_csr_rdata <= rdata_nxt;
            state             <= CMPLT;
          end
        end
        CMPLT: state <= WAITDRP;
        WAITDRP: begin
          if (!biu_pad_csr_sel) begin
            l2c_csr_busy <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ct_l2c_csr_resp.sv
// Directed self-checking bench for ct_l2c_csr_resp with default parameters.
module tb_ct_l2c_csr_resp;

  localparam logic [63:0] VER = 64'h0000_0000_0001_0000;

  logic         coreclk = 1'b0;
  logic         cpurst;
  logic         sel;
  logic [79:0]  wdata;
  logic         cmplt;
  logic [127:0] rdata;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  ct_l2c_csr_resp #(
    .NUM_REGS (8),
    .RESP_LAT (2),
    .VERSION  (VER)
  ) dut (
    .coreclk           (coreclk),
    .cpurst            (cpurst),
    .biu_pad_csr_sel   (sel),
    .biu_pad_csr_wdata (wdata),
    .pad_biu_csr_cmplt (cmplt),
    .pad_biu_csr_rdata (rdata),
    .l2c_csr_busy      (busy)
  );

  always #5 coreclk = ~coreclk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge coreclk);
    #1;
  endtask

  // Full handshake; payload is scrambled after capture to prove it is not re-sampled.
  task automatic do_req(input logic wr, input logic [7:0] idx, input logic [63:0] data,
                        output logic [127:0] rd, output int lat);
    sel   = 1'b1;
    wdata = {wr, 7'b0, idx, data};
    lat   = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) wdata = ~wdata;
    end while (!cmplt && lat < 40);
    rd = rdata;
    check("cmplt_seen", {127'b0, cmplt}, 128'd1);
    check("busy_at_cmplt", {127'b0, busy}, 128'd1);
    tick();
    check("single_pulse", {127'b0, cmplt}, 128'd0);
    sel = 1'b0;
    tick();
    check("busy_clear", {127'b0, busy}, 128'd0);
    tick();
  endtask

  logic [127:0] rd;
  int           lat;
  int           cnt_pulse;
  int           cnt_idle;

  initial begin
    cpurst = 1'b1;
    sel    = 1'b0;
    wdata  = '0;
    repeat (2) tick();
    check("rst_cmplt", {127'b0, cmplt}, 128'd0);
    check("rst_rdata", rdata, 128'd0);
    check("rst_busy", {127'b0, busy}, 128'd0);
    cpurst = 1'b0;
    tick();

    do_req(1'b1, 8'd3, 64'hDEAD_BEEF_0123_4567, rd, lat);
    check("wr3_lat", 128'(lat), 128'd4);
    check("wr3_echo", rd, {64'b0, 64'hDEAD_BEEF_0123_4567});
    do_req(1'b0, 8'd3, 64'h0, rd, lat);
    check("rd3_lat", 128'(lat), 128'd4);
    check("rd3_data", rd, {64'b0, 64'hDEAD_BEEF_0123_4567});

    do_req(1'b0, 8'd8, 64'h0, rd, lat);
    check("rd8_err", rd, {63'b0, 1'b1, 64'b0});
    do_req(1'b1, 8'd0, 64'hFFFF_0000_FFFF_0000, rd, lat);
    do_req(1'b0, 8'd0, 64'h0, rd, lat);
    check("rd0_version", rd, {64'b0, VER});

    do_req(1'b1, 8'd7, 64'h0F0F_1234_5678_9ABC, rd, lat);
    do_req(1'b0, 8'd7, 64'h0, rd, lat);
    check("rd7_data", rd, {64'b0, 64'h0F0F_1234_5678_9ABC});
    do_req(1'b0, 8'd1, 64'h0, rd, lat);
    check("rd1_zero", rd, 128'd0);
    do_req(1'b0, 8'd3, 64'h0, rd, lat);
    check("rd3_kept", rd, {64'b0, 64'hDEAD_BEEF_0123_4567});

    // Held sel: no restart while sel stays high.
    sel   = 1'b1;
    wdata = {1'b0, 7'b0, 8'd3, 64'h0};
    lat   = 0;
    do begin
      tick();
      lat++;
    end while (!cmplt && lat < 40);
    check("held_cmplt", {127'b0, cmplt}, 128'd1);
    cnt_pulse = 0;
    cnt_idle  = 0;
    repeat (20) begin
      tick();
      if (cmplt) cnt_pulse++;
      if (!busy) cnt_idle++;
    end
    check("held_no_pulse", 128'(cnt_pulse), 128'd0);
    check("held_busy", 128'(cnt_idle), 128'd0);
    sel = 1'b0;
    tick();
    check("held_drop_busy", {127'b0, busy}, 128'd0);
    tick();

    // Early drop during ACCESS.
    sel   = 1'b1;
    wdata = {1'b1, 7'b0, 8'd2, 64'h1357_2468_ACE0_BDF1};
    tick();
    sel = 1'b0;
    lat = 1;
    do begin
      tick();
      lat++;
    end while (!cmplt && lat < 40);
    check("early_lat", 128'(lat), 128'd4);
    check("early_echo", rdata, {64'b0, 64'h1357_2468_ACE0_BDF1});
    tick();
    check("early_pulse", {127'b0, cmplt}, 128'd0);
    check("early_waitdrp", {127'b0, busy}, 128'd1);
    tick();
    check("early_idle", {127'b0, busy}, 128'd0);
    tick();
    do_req(1'b0, 8'd2, 64'h0, rd, lat);
    check("early_rd2", rd, {64'b0, 64'h1357_2468_ACE0_BDF1});

    // Reset during ACCESS of a write to index 5.
    do_req(1'b1, 8'd5, 64'h5555_AAAA_1234_8765, rd, lat);
    sel   = 1'b1;
    wdata = {1'b1, 7'b0, 8'd5, 64'hFFFF_EEEE_DDDD_CCCC};
    tick();
    tick();
    #2 cpurst = 1'b1;
    #1;
    check("mid_rst_cmplt", {127'b0, cmplt}, 128'd0);
    check("mid_rst_rdata", rdata, 128'd0);
    check("mid_rst_busy", {127'b0, busy}, 128'd0);
    @(posedge coreclk);
    #1;
    cpurst = 1'b0;
    sel    = 1'b0;
    cnt_pulse = 0;
    repeat (8) begin
      tick();
      if (cmplt) cnt_pulse++;
    end
    check("mid_rst_no_cmplt", 128'(cnt_pulse), 128'd0);
    do_req(1'b0, 8'd5, 64'h0, rd, lat);
    check("mid_rst_rd5", rd, 128'd0);
    do_req(1'b0, 8'd3, 64'h0, rd, lat);
    check("mid_rst_rd3", rd, 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
